// File: rtl/i2c_io_regs.sv
// Register bank behind an I2C slave: scratch, synchronized GPIO input with edge status, OE and PWM output.
// Optional accumulator PWM is built only when I2C_IO_REGS_PWM_EN is defined.
module i2c_io_regs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       wen,
  input  logic [7:0] wdata,
  input  logic       rdata_used,
  output logic [7:0] rdata,
  input  logic [7:0] gpio_in,
  output logic       gpio_out,
  output logic       gpio_oe,
  output logic       irq
);

  localparam int unsigned DW     = 8;
  localparam int unsigned NSCR   = 4;
  localparam int unsigned NSTAT  = 2;

  logic [DW-1:0]    scratch_q [NSCR];
  logic             oe_q;
  logic [DW-1:0]    pwm_q;
  logic [NSTAT-1:0] status_q;
  logic [NSTAT-1:0] status_nxt;
  logic             irq_q;
  logic [DW-1:0]    rdata_q;
  logic [DW-1:0]    sync1_q;
  logic [DW-1:0]    sync2_q;
  logic [1:0]       vld_q;
  logic [DW-1:0]    rd_c;
  logic             in_range;
  logic             rise;
  logic             fall;
  logic             clr;

  assign in_range = (addr[7:3] == 5'd0);

  // Read mux over current register contents; rdata is this value one cycle later.
  always_comb begin
    rd_c = '0;
    if (in_range) begin
      case (addr[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: rd_c = scratch_q[addr[1:0]];
        3'd4:                   rd_c = sync2_q;
        3'd5:                   rd_c = {7'd0, oe_q};
        3'd6:                   rd_c = pwm_q;
        default:                rd_c = {6'd0, status_q};
      endcase
    end
  end

  // vld_q[1] marks that sync2 already held a real sample, so the first post-reset sample never flags.
  assign rise = vld_q[1] &  sync1_q[0] & ~sync2_q[0];
  assign fall = vld_q[1] & ~sync1_q[0] &  sync2_q[0];
  assign clr  = rdata_used && (addr == 8'h07);

  // Clear then set, so an edge arriving with the clear keeps its bit.
  always_comb begin
    status_nxt = status_q;
    if (clr) status_nxt = '0;
    status_nxt = status_nxt | {fall, rise};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSCR; i++) scratch_q[i] <= '0;
      oe_q     <= 1'b0;
      pwm_q    <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      vld_q    <= '0;
    end else begin
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      vld_q    <= {vld_q[0], 1'b1};
      status_q <= status_nxt;
      irq_q    <= |status_nxt;
      rdata_q  <= rd_c;
      if (wen && in_range) begin
        case (addr[2:0])
          3'd0, 3'd1, 3'd2, 3'd3: scratch_q[addr[1:0]] <= wdata;
          3'd5:                   oe_q  <= wdata[0];
          3'd6:                   pwm_q <= wdata;
          default:                ;
        endcase
      end
    end
  end

`ifdef I2C_IO_REGS_PWM_EN
  logic [DW-1:0] acc_q;

  // First-order accumulator: bit 7 is the carry out of the 7-bit phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (!pwm_q[7]) begin
      acc_q <= {1'b0, acc_q[6:0]} + {1'b0, pwm_q[6:0]};
    end
  end

  assign gpio_out = pwm_q[7] ? pwm_q[0] : acc_q[7];
`else
  assign gpio_out = pwm_q[0];
`endif

  assign gpio_oe = oe_q;
  assign irq     = irq_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_io_regs.sv
// Self-checking bench for i2c_io_regs: behavioural model compared every cycle plus directed literal checks.
module tb_i2c_io_regs;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic       wen;
  logic [7:0] wdata;
  logic       rdata_used;
  logic [7:0] rdata;
  logic [7:0] gpio_in;
  logic       gpio_out;
  logic       gpio_oe;
  logic       irq;

  int checks = 0;
  int errors = 0;

  i2c_io_regs dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wen(wen), .wdata(wdata),
    .rdata_used(rdata_used), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: register file by address, gpio samples since reset, PWM phase.
  logic [7:0] m_reg [8];
  logic [7:0] m_samp [$];
  logic [7:0] m_rdata;
  int         m_n;
  int         m_frac;
  bit         m_carry;
  bit         m_live = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_gpio_out();
`ifdef I2C_IO_REGS_PWM_EN
    return m_reg[6][7] ? m_reg[6][0] : m_carry;
`else
    return m_reg[6][0];
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_samp.delete();
      m_n = 0; m_frac = 0; m_carry = 1'b0; m_rdata = 8'h00; m_live = 1'b1;
    end else if (m_live) begin
      logic [7:0] cur_sync;
      logic [7:0] setbits;
      cur_sync = (m_n >= 2) ? m_samp[m_n-2] : 8'h00;
      if (addr >= 8)       m_rdata = 8'h00;
      else if (addr == 4)  m_rdata = cur_sync;
      else                 m_rdata = m_reg[addr[2:0]];
      if (!m_reg[6][7]) begin
        m_frac  = m_frac + int'(m_reg[6][6:0]);
        m_carry = (m_frac >= 128);
        m_frac  = m_frac % 128;
      end
      setbits = 8'h00;
      if (m_n >= 2 && m_samp[m_n-1][0] != m_samp[m_n-2][0])
        setbits = m_samp[m_n-1][0] ? 8'h01 : 8'h02;
      if (rdata_used && addr == 8'h07) m_reg[7] = 8'h00;
      m_reg[7] = m_reg[7] | setbits;
      if (wen && addr < 8 && addr != 4 && addr != 7)
        m_reg[addr[2:0]] = (addr == 5) ? (wdata & 8'h01) : wdata;
      m_samp.push_back(gpio_in);
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("rdata_model", rdata, m_rdata);
      chk("gpio_out_model", {7'd0, gpio_out}, {7'd0, exp_gpio_out()});
      chk("gpio_oe_model", {7'd0, gpio_oe}, m_reg[5] & 8'h01);
      chk("irq_model", {7'd0, irq}, {7'd0, (m_reg[7] != 8'h00)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    tick();
    chk(name, rdata, exp);
  endtask

  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0; addr = 8'h00; wen = 1'b0; wdata = 8'h00; rdata_used = 1'b0; gpio_in = 8'h00;
    tick(); tick();
    chk("rst_gpio_oe", {7'd0, gpio_oe}, 8'h00);
    chk("rst_gpio_out", {7'd0, gpio_out}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd("rst_read", 8'(a), 8'h00);

    wr(8'h02, 8'hA5);
    rd("scratch2", 8'h02, 8'hA5);
    wr(8'h0A, 8'hFF);
    rd("oor_read", 8'h0A, 8'h00);
    rd("scratch0", 8'h00, 8'h00);
    rd("scratch2_kept", 8'h02, 8'hA5);
    wr(8'h04, 8'h5A);
    rd("gpio_in_ro", 8'h04, 8'h00);

    wr(8'h06, 8'h20);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin tick(); cnt += int'(gpio_out); end
`ifdef I2C_IO_REGS_PWM_EN
    chk("pwm_duty32", 8'(cnt), 8'd32);
`else
    chk("pwm_off_static", 8'(cnt), 8'd0);
`endif
    wr(8'h06, 8'h81);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(gpio_out); end
    chk("pwm_static1", 8'(cnt), 8'd20);
    wr(8'h06, 8'h80);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(gpio_out); end
    chk("pwm_static0", 8'(cnt), 8'd0);
    rd("pwm_read", 8'h06, 8'h80);

    addr = 8'h00;
    gpio_in = 8'h01;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin tick(); seen = irq; end
    chk("rise_irq", {7'd0, seen}, 8'h01);
    rd("status_rise", 8'h07, 8'h01);
    rdata_used = 1'b1;
    tick();
    rdata_used = 1'b0;
    chk("clear_irq", {7'd0, irq}, 8'h00);
    rd("status_cleared", 8'h07, 8'h00);

    gpio_in = 8'h00;
    tick();
    rdata_used = 1'b1;
    tick();
    rdata_used = 1'b0;
    chk("fall_set_wins_irq", {7'd0, irq}, 8'h01);
    rd("status_fall", 8'h07, 8'h02);
    wr(8'h07, 8'h00);
    rd("status_wr_noclr", 8'h07, 8'h02);
    addr = 8'h07; wdata = 8'hFF; wen = 1'b1; rdata_used = 1'b1;
    tick();
    wen = 1'b0; rdata_used = 1'b0;
    chk("wen_used_clr_irq", {7'd0, irq}, 8'h00);

    wr(8'h05, 8'h01);
    chk("oe_set", {7'd0, gpio_oe}, 8'h01);
    wr(8'h05, 8'hFF);
    rd("oe_bit0_only", 8'h05, 8'h01);
    wr(8'h06, 8'h20);
    gpio_in = 8'h01;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_irq", {7'd0, irq}, 8'h01);
    rst_n = 1'b0;
    tick();
    chk("midrst_gpio_oe", {7'd0, gpio_oe}, 8'h00);
    chk("midrst_gpio_out", {7'd0, gpio_out}, 8'h00);
    chk("midrst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("first_sample_noflag", {7'd0, irq}, 8'h00);
    rd("pwm_after_rst", 8'h06, 8'h00);
    rd("gpio_in_sync", 8'h04, 8'h01);
    rd("scratch2_after_rst", 8'h02, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_io_regs.md
I2C_IO_REGS -- requirements
Module: i2c_io_regs

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning; reset is rst_n, synchronous, active-low; clock is clk.
- clk  in  1  system clock (25-50 MHz).
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- addr  in  8  register address from the I2C slave application interface.
- wen  in  1  one-cycle write strobe; wdata is valid with it.
- wdata  in  8  write data.
- rdata_used  in  1  one-cycle pulse; the slave has consumed the current rdata.
- rdata  out  8  read data for addr.
- gpio_in  in  8  asynchronous external inputs.
- gpio_out  out  1  output pin value.
- gpio_oe  out  1  output pin enable.
- irq  out  1  high while any STATUS bit is set.

Function
REQ-002 SHALL decode addr[2:0] only when addr[7:3]==0. Otherwise writes are ignored and rdata reads 0x00.
REQ-003 SHALL implement this map:
- 0-3 SCRATCH: R/W.
- 4 GPIO_IN: read-only.
- 5 OE: R/W, bit0 only; bits 7:1 read 0.
- 6 PWM: R/W.
- 7 STATUS: read-only, read-to-clear.
REQ-004 SHALL synchronize gpio_in through two flops. GPIO_IN SHALL return the second-stage value.
REQ-005 SHALL register rdata: rdata at cycle N+1 reflects addr and register contents at cycle N (1-cycle latency).
REQ-006 SHALL update the addressed register on the posedge where wen=1. The new value SHALL be visible on rdata one cycle after the write.
REQ-007 SHALL drive gpio_oe = OE[0] directly from the register.
REQ-008 SHALL run a first-order PWM accumulator every clk cycle when PWM[7]=0:
- acc <= {1'b0, acc[6:0]} + PWM[6:0];
- gpio_out = acc[7].
REQ-009 The average duty SHALL be PWM[6:0]/128. PWM[6:0]=0 SHALL give constant 0.
REQ-010 When PWM[7]=1, gpio_out SHALL equal PWM[0] statically. acc SHALL hold its value.
REQ-011 STATUS bit0 SHALL set on a 0->1 transition of synchronized gpio_in[0]. STATUS bit1 SHALL set on a 1->0 transition. Bits 7:2 SHALL read 0.
REQ-012 On rdata_used=1 with addr==0x07, STATUS SHALL clear.
REQ-013 If a new edge occurs in the same cycle as the clear, the corresponding bit SHALL remain set (set wins).
REQ-014 SHALL ignore writes to addresses 4 and 7. Writes to 4 and 7 SHALL NOT clear STATUS.
REQ-015 irq SHALL equal |STATUS[1:0], registered together with STATUS.
REQ-016 wen and rdata_used asserted in the same cycle SHALL both take effect independently.

Reset
REQ-017 On rst_n=0 at posedge clk, the following SHALL reset to 0x00:
- SCRATCH, OE, PWM, STATUS, acc, rdata, and both synchronizer stages.
REQ-018 During and after reset: gpio_out=0, gpio_oe=0, irq=0. Edge detection SHALL NOT flag the first synchronized sample after reset.
REQ-019 Reset asserted mid-operation SHALL abort PWM output and drop any pending status within the same cycle.

Configuration
REQ-020 Macro I2C_IO_REGS_PWM_EN SHALL control the PWM feature:
- Defined: PWM behaves per REQ-008..010.
- Not defined: no accumulator is built, and gpio_out = PWM[0] always. Register 6 SHALL remain R/W storage.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then read addresses 0-7 -> 0x00 each; gpio_oe=0, gpio_out=0, irq=0.
- Write 0xA5 to addr 2, then read addr 2 -> rdata=0xA5 one cycle after addr presented; addr 0x0A write 0xFF -> no register changes, read 0x0A -> 0x00.
- PWM=0x20 (macro defined), run 128 cycles -> gpio_out high exactly 32 cycles. PWM=0x81 -> gpio_out constant 1; PWM=0x80 -> constant 0.
- gpio_in[0] 0->1 -> STATUS=0x01 and irq=1 within 3 cycles. rdata_used at addr 7 -> STATUS=0x00, irq=0 next cycle.
- Falling edge on gpio_in[0] synchronized in the same cycle as a rdata_used clear at addr 7 -> STATUS=0x02 remains, irq stays 1.
- Write 0x01 to addr 5 -> gpio_oe=1. Assert rst_n=0 for 1 cycle mid-PWM -> gpio_oe=0, gpio_out=0, PWM reads 0x00.
